// File: rtl/io_irq_controller.sv
// Interrupt producer for the CPU: latches device request edges, picks the lowest
// enabled source, raises it on io_in and tracks it through acknowledge and kernel return.
module io_irq_controller #(
   parameter int HOLDOFF     = 2,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [15:0] dev_req,
   input  logic        mask_we,
   input  logic [15:0] mask_wdata,
   input  logic        in_kernel,
   input  logic        kernel_done,
   output logic [15:0] io_in,
   output logic [3:0]  irq_id,
   output logic [15:0] pending,
   output logic        busy,
   output logic        timeout_err,
   output logic [15:0] irq_count
);

   localparam int TMAX = (ACK_TIMEOUT > HOLDOFF) ? ACK_TIMEOUT : HOLDOFF;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_SERVICE = 2'd2,
      S_RETIRE  = 2'd3
   } state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [15:0]   r_prev_req;
   logic [15:0]   r_mask;
   logic [15:0]   r_pending;
   logic [15:0]   r_io_in;
   logic [3:0]    r_irq_id;
   logic          r_timeout_err;
   logic [15:0]   r_irq_count;

   logic [15:0]   w_rise;
   logic [15:0]   w_eligible;
   logic [15:0]   w_clr;
   logic [3:0]    w_sel;
   logic          w_any;

   assign w_rise     = dev_req & ~r_prev_req;
   assign w_eligible = r_pending & r_mask;
   assign w_any      = |w_eligible;
   assign w_clr      = (r_state == S_ASSERT && in_kernel) ? (16'h0001 << r_irq_id) : 16'h0000;

   // Scan from the top so the lowest eligible index is the last one written.
   always_comb begin
      w_sel = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (w_eligible[i]) w_sel = 4'(i);
      end
   end

   // Handshake: io_in stays one-hot and stable in ASSERT until in_kernel is seen
   // high (accept) or the ack timer expires; kernel_done then closes the service.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_prev_req    <= 16'h0000;
         r_mask        <= 16'hFFFF;
         r_pending     <= 16'h0000;
         r_io_in       <= 16'h0000;
         r_irq_id      <= 4'd0;
         r_timeout_err <= 1'b0;
         r_irq_count   <= 16'h0000;
      end else begin
         r_prev_req <= dev_req;
         if (mask_we) r_mask <= mask_wdata;
         // A new edge on the bit being acknowledged survives the clear.
         r_pending <= (r_pending & ~w_clr) | w_rise;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_irq_id <= w_sel;
                  r_io_in  <= 16'h0001 << w_sel;
                  r_timer  <= '0;
                  r_state  <= S_ASSERT;
               end else begin
                  r_io_in <= 16'h0000;
               end
            end
            S_ASSERT: begin
               if (in_kernel) begin
                  r_io_in <= 16'h0000;
                  if (r_irq_count != 16'hFFFF) r_irq_count <= r_irq_count + 16'd1;
                  r_state <= S_SERVICE;
               end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                  r_io_in       <= 16'h0000;
                  r_timeout_err <= 1'b1;
                  r_timer       <= '0;
                  r_state       <= S_RETIRE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_SERVICE: begin
               r_io_in <= 16'h0000;
               if (kernel_done) begin
                  r_timer <= '0;
                  r_state <= S_RETIRE;
               end
            end
            S_RETIRE: begin
               r_io_in <= 16'h0000;
               if (r_timer == TW'(HOLDOFF - 1)) r_state <= S_IDLE;
               else                             r_timer <= r_timer + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_in       = r_io_in;
   assign irq_id      = r_irq_id;
   assign pending     = r_pending;
   assign busy        = (r_state != S_IDLE);
   assign timeout_err = r_timeout_err;
   assign irq_count   = r_irq_count;

endmodule

// File: doc/io_irq_controller.md
Name: io_irq_controller

Overview:
- Producer side of the CPU interrupt interface: collects device requests, arbitrates them, and drives the 16-bit `io_in` vector that the control unit samples to enter the kernel state.
- Tracks the request through acknowledge (`in_kernel` high) and kernel return (`kernel_done` pulse, issued when the PC-255 return fetch executes).
- Raises only one interrupt at a time, enforces a holdoff gap between interrupts, and supports per-source masking.

Parameters:
- HOLDOFF, default 2: idle cycles forced after kernel return before the next request may be raised (minimum 1).
- ACK_TIMEOUT, default 64: cycles to wait for `in_kernel` after raising `io_in` before abandoning the attempt (minimum 2).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- dev_req  input  16  device request lines, level; a 0→1 transition is a request.
- mask_we  input  1  write enable for the mask register.
- mask_wdata  input  16  new mask value; 1 = source enabled.
- in_kernel  input  1  control-unit acknowledge; high while the kernel runs.
- kernel_done  input  1  one-cycle pulse when the kernel return executes.
- io_in  output  16  one-hot request vector to the control unit; 0 = no interrupt.
- irq_id  output  4  index of the source currently raised or in service.
- pending  output  16  latched, unserviced requests.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky; set when an acknowledge timeout occurs.
- irq_count  output  16  count of serviced interrupts, saturating at 16'hFFFF.

Behaviour:
- Reset (async, immediate): all outputs 0; mask = 16'hFFFF; `dev_req` history register = 0; state = IDLE.
- Edge detection:
  - `prev_req` is registered each cycle.
  - `pending[i]` is set when `dev_req[i] & ~prev_req[i]`.
  - Masked sources still latch into `pending` but are not eligible for arbitration.
- Eligible set = `pending & mask`.
- Mask write: takes effect on the next edge. If the mask write and arbitration fall in the same cycle, arbitration uses the old mask.
- Arbitration: lowest eligible index wins (bit 0 has highest priority). The selected index is latched into `irq_id`.
- State machine:
  - IDLE: if eligible ≠ 0, latch `irq_id`, drive `io_in = 1<<irq_id`, clear the timer, go to ASSERT. Otherwise `io_in = 0`.
  - ASSERT:
    - `io_in` is held stable, with no re-arbitration even if a higher-priority source arrives.
    - If `in_kernel == 1`: clear `pending[irq_id]`, `io_in = 0`, increment `irq_count` (saturating), go to SERVICE.
    - Else if timer == ACK_TIMEOUT-1: `io_in = 0`, set `timeout_err`, leave the pending bit set, go to RETIRE.
    - Otherwise increment the timer.
  - SERVICE: `io_in = 0`. On `kernel_done`, go to RETIRE. If `in_kernel` is already low on entry, still wait for `kernel_done`.
  - RETIRE: count HOLDOFF cycles with `io_in = 0`, then go to IDLE. `irq_id` is held until IDLE re-arbitrates.
- Latency: request edge at cycle N → `pending` visible at N+1 → `io_in` asserted at N+2 when IDLE and unmasked.
- Simultaneous events:
  - Set and clear of the same pending bit in one cycle: set wins, so a re-request during acknowledge is not lost.
  - `kernel_done` seen in ASSERT is ignored.
  - `in_kernel` high in IDLE is ignored.
- `timeout_err` clears only on Reset.
- Reset asserted mid-operation: immediate return to IDLE with `io_in = 0`. All pending requests are discarded.

Test Plan:
- Reset, then `dev_req` = 16'h0008 at cycle 5 → `pending` = 16'h0008 at cycle 6; `io_in` = 16'h0008 and `irq_id` = 3 at cycle 7; `in_kernel` = 1 at cycle 10 → `io_in` = 0, `pending` = 0, `irq_count` = 1.
- `dev_req` = 16'h0120 in the same cycle → source 5 served first (`io_in` = 16'h0020). After `kernel_done` plus 2 holdoff cycles, `io_in` = 16'h0100 and `irq_id` = 8.
- Mask = 16'hFFFE, `dev_req[0]` rises → `pending` = 16'h0001 and `io_in` stays 0. Write mask = 16'hFFFF → `io_in` = 16'h0001 two cycles later.
- Raise source 2 and never assert `in_kernel` → after 64 cycles `io_in` = 0 and `timeout_err` = 1. `pending[2]` stays set, and source 2 is re-raised after the holdoff.
- Source 4 re-pulses in the same cycle `in_kernel` acknowledges it → `pending[4]` remains 1 and is served a second time (`irq_count` = 2).
- Assert Reset while in SERVICE with `pending` = 16'h00F0 → `io_in`, `pending`, `irq_count` and `busy` are 0 immediately, without waiting for a clock edge.
